wb_stage_regfile: RTL and testbench

// - Write-back stage and integer register file; consumes the MEM/WB pipeline register outputs.
// - Selects the write-back value, then aligns and sign-/zero-extends load data.
// - Writes the 32x32 register file and serves the two decode-stage read ports with same-cycle bypass.
// - Keeps retired-instruction and invalid-instruction counters.

---
 rtl/wb_stage_regfile_pkg.sv | 20 ++
 rtl/wb_stage_regfile_load_align.sv | 57 +++++
 rtl/wb_stage_regfile.sv | 141 ++++++++++++++
 tb/tb_wb_stage_regfile.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_regfile_pkg.sv
// Shared types and constants for the write-back stage and register file.
// Covers the write-back source encoding, the load funct3 codes and the bubble encoding.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_ALU  = 2'b00,
        WB_LOAD = 2'b01,
        WB_IMM  = 2'b10,
        WB_PC4  = 2'b11
    } regin_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [31:0] NOP_BUBBLE = 32'h0000_0000;

endpackage

// File: rtl/wb_stage_regfile_load_align.sv
// Combinational load alignment: picks the addressed byte or half from the read word,
// sign/zero-extends it, and flags alignment violations. Unknown funct3 behaves as LW.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Byte and halfword lane selection from the byte offset
    always_comb begin
        byte_s = rdata[7:0];
        case (off)
            2'b00:   byte_s = rdata[7:0];
            2'b01:   byte_s = rdata[15:8];
            2'b10:   byte_s = rdata[23:16];
            2'b11:   byte_s = rdata[31:24];
            default: byte_s = rdata[7:0];
        endcase
        if (off[1]) begin
            half_s = rdata[31:16];
        end else begin
            half_s = rdata[15:0];
        end
    end

    // Extension and misalignment detection by access size
    always_comb begin
        data       = rdata;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:   data = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_s};
            F3_LH: begin
                data       = {{(XLEN-16){half_s[15]}}, half_s};
                misaligned = off[0];
            end
            F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_s};
                misaligned = off[0];
            end
            default: begin
                data       = rdata;
                misaligned = (off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage_regfile.sv
// Write-back stage plus 32x32 integer register file with same-cycle read bypass,
// retired/invalid instruction counters and a registered misaligned-load pulse.
module wb_stage_regfile
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int CNT_W  = 64,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memtoreg_in,
    input  logic             regwrite_in,
    input  logic [1:0]       regin_in,
    input  logic [XLEN-1:0]  ALUout_in,
    input  logic [XLEN-1:0]  Rdata_in,
    input  logic [XLEN-1:0]  immgen_in,
    input  logic [XLEN-1:0]  PC_plus4_in,
    input  logic [31:0]      inst_data_in,
    input  logic [XLEN-1:0]  Data_addr_in,
    input  logic             invalid_in,
    input  logic [4:0]       rs1_addr_i,
    input  logic [4:0]       rs2_addr_i,
    output logic [XLEN-1:0]  rs1_data_o,
    output logic [XLEN-1:0]  rs2_data_o,
    output logic             wb_en_o,
    output logic [4:0]       wb_rd_o,
    output logic [XLEN-1:0]  wb_data_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] instret_o,
    output logic [CNT_W-1:0] invalid_cnt_o
);

    logic [XLEN-1:0]  regs_r [0:NREGS-1];
    logic [CNT_W-1:0] instret_r;
    logic [CNT_W-1:0] invalid_cnt_r;
    logic             misalign_r;

    logic [XLEN-1:0]  load_data_s;
    logic             load_mis_s;
    logic             load_sel_s;
    logic             misaligned_s;
    logic [XLEN-1:0]  wb_data_s;
    logic [4:0]       wb_rd_s;
    logic             wb_en_s;
    logic             valid_inst_s;
    logic             retire_s;
    logic             inval_s;
    logic [XLEN-1:0]  rs1_data_s;
    logic [XLEN-1:0]  rs2_data_s;
    logic             unused_s;

    assign unused_s = ^{inst_data_in[31:15], inst_data_in[6:0], Data_addr_in[XLEN-1:2]};

    wb_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata      (Rdata_in),
        .off        (Data_addr_in[1:0]),
        .funct3     (inst_data_in[14:12]),
        .data       (load_data_s),
        .misaligned (load_mis_s)
    );

    assign load_sel_s   = memtoreg_in | (regin_in == WB_LOAD);
    assign misaligned_s = load_sel_s & load_mis_s;
    assign wb_rd_s      = inst_data_in[11:7];
    assign wb_en_s      = regwrite_in & ~invalid_in & ~misaligned_s & (wb_rd_s != 5'd0);
    assign valid_inst_s = (inst_data_in != NOP_BUBBLE);
    assign retire_s     = valid_inst_s & ~invalid_in;
    assign inval_s      = valid_inst_s & invalid_in;

    // Write-back source select; memtoreg overrides regin
    always_comb begin
        wb_data_s = ALUout_in;
        if (memtoreg_in) begin
            wb_data_s = load_data_s;
        end else begin
            case (regin_e'(regin_in))
                WB_ALU:  wb_data_s = ALUout_in;
                WB_LOAD: wb_data_s = load_data_s;
                WB_IMM:  wb_data_s = immgen_in;
                WB_PC4:  wb_data_s = PC_plus4_in;
                default: wb_data_s = ALUout_in;
            endcase
        end
    end

    // Read ports: x0 is hardwired zero, then bypass, then array
    always_comb begin
        rs1_data_s = regs_r[rs1_addr_i];
        rs2_data_s = regs_r[rs2_addr_i];
        if (rs1_addr_i == 5'd0) begin
            rs1_data_s = {XLEN{1'b0}};
        end else if ((BYPASS != 0) && wb_en_s && (rs1_addr_i == wb_rd_s)) begin
            rs1_data_s = wb_data_s;
        end else begin
            rs1_data_s = regs_r[rs1_addr_i];
        end
        if (rs2_addr_i == 5'd0) begin
            rs2_data_s = {XLEN{1'b0}};
        end else if ((BYPASS != 0) && wb_en_s && (rs2_addr_i == wb_rd_s)) begin
            rs2_data_s = wb_data_s;
        end else begin
            rs2_data_s = regs_r[rs2_addr_i];
        end
    end

    // Register array; entry 0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_r[i] <= {XLEN{1'b0}};
            end
        end else if (wb_en_s) begin
            regs_r[wb_rd_s] <= wb_data_s;
        end
    end

    // Retire/invalid counters and misaligned pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instret_r     <= {CNT_W{1'b0}};
            invalid_cnt_r <= {CNT_W{1'b0}};
            misalign_r    <= 1'b0;
        end else begin
            instret_r     <= instret_r + {{(CNT_W-1){1'b0}}, retire_s};
            invalid_cnt_r <= invalid_cnt_r + {{(CNT_W-1){1'b0}}, inval_s};
            misalign_r    <= misaligned_s & valid_inst_s;
        end
    end

    assign rs1_data_o    = rs1_data_s;
    assign rs2_data_o    = rs2_data_s;
    assign wb_en_o       = wb_en_s;
    assign wb_rd_o       = wb_rd_s;
    assign wb_data_o     = wb_data_s;
    assign misalign_o    = misalign_r;
    assign instret_o     = instret_r;
    assign invalid_cnt_o = invalid_cnt_r;

endmodule

// File: tb/tb_wb_stage_regfile.sv
// Directed self-checking bench for wb_stage_regfile: ALU/load write-back, bypass,
// misaligned loads, x0 protection, invalid/bubble counting and async reset.
module tb_wb_stage_regfile;

    logic        clk;
    logic        reset;
    logic        memtoreg_in;
    logic        regwrite_in;
    logic [1:0]  regin_in;
    logic [31:0] ALUout_in;
    logic [31:0] Rdata_in;
    logic [31:0] immgen_in;
    logic [31:0] PC_plus4_in;
    logic [31:0] inst_data_in;
    logic [31:0] Data_addr_in;
    logic        invalid_in;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic [31:0] rs1_data_o;
    logic [31:0] rs2_data_o;
    logic        wb_en_o;
    logic [4:0]  wb_rd_o;
    logic [31:0] wb_data_o;
    logic        misalign_o;
    logic [63:0] instret_o;
    logic [63:0] invalid_cnt_o;

    int total;
    int bad;
    logic [63:0] exp_ret;
    logic [63:0] exp_inv;

    wb_stage_regfile dut (
        .clk           (clk),
        .reset         (reset),
        .memtoreg_in   (memtoreg_in),
        .regwrite_in   (regwrite_in),
        .regin_in      (regin_in),
        .ALUout_in     (ALUout_in),
        .Rdata_in      (Rdata_in),
        .immgen_in     (immgen_in),
        .PC_plus4_in   (PC_plus4_in),
        .inst_data_in  (inst_data_in),
        .Data_addr_in  (Data_addr_in),
        .invalid_in    (invalid_in),
        .rs1_addr_i    (rs1_addr_i),
        .rs2_addr_i    (rs2_addr_i),
        .rs1_data_o    (rs1_data_o),
        .rs2_data_o    (rs2_data_o),
        .wb_en_o       (wb_en_o),
        .wb_rd_o       (wb_rd_o),
        .wb_data_o     (wb_data_o),
        .misalign_o    (misalign_o),
        .instret_o     (instret_o),
        .invalid_cnt_o (invalid_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] rd, input logic [2:0] f3, input logic [6:0] opc);
        return {17'h0_0000, f3, rd, opc};
    endfunction

    task automatic idle();
        memtoreg_in  = 1'b0;
        regwrite_in  = 1'b0;
        regin_in     = 2'b00;
        inst_data_in = 32'h0000_0000;
        invalid_in   = 1'b0;
        Data_addr_in = 32'h0000_0000;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        memtoreg_in  = 1'b1;
        regwrite_in  = 1'b1;
        regin_in     = 2'b01;
        inst_data_in = mk(rd, f3, 7'h03);
        Data_addr_in = {30'h0000_1000, off};
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] v);
        memtoreg_in  = 1'b0;
        regwrite_in  = 1'b1;
        regin_in     = 2'b00;
        ALUout_in    = v;
        inst_data_in = mk(rd, 3'b000, 7'h33);
    endtask

    initial begin
        total = 0; bad = 0; exp_ret = 64'd0; exp_inv = 64'd0;
        reset = 1'b1;
        idle();
        ALUout_in = 32'h0; Rdata_in = 32'h8081_7F12;
        immgen_in = 32'h0; PC_plus4_in = 32'h0;
        rs1_addr_i = 5'd5; rs2_addr_i = 5'd0;
        #12;
        chk("rst_instret", instret_o, 64'd0);
        chk("rst_invalid", invalid_cnt_o, 64'd0);
        chk("rst_misalign", {63'd0, misalign_o}, 64'd0);
        chk("rst_x5", {32'd0, rs1_data_o}, 64'd0);
        reset = 1'b0;
        tick();

        // ALU write to x5 with same-cycle bypass on port B
        alu(5'd5, 32'hDEAD_BEEF);
        rs1_addr_i = 5'd0; rs2_addr_i = 5'd5;
        #2;
        chk("alu_wb_en", {63'd0, wb_en_o}, 64'd1);
        chk("alu_wb_rd", {59'd0, wb_rd_o}, 64'd5);
        chk("alu_bypass_rs2", {32'd0, rs2_data_o}, 64'h0000_0000_DEAD_BEEF);
        chk("alu_rs1_x0", {32'd0, rs1_data_o}, 64'd0);
        tick(); exp_ret++;
        idle();
        rs1_addr_i = 5'd5;
        #2;
        chk("alu_read_x5", {32'd0, rs1_data_o}, 64'h0000_0000_DEAD_BEEF);
        chk("alu_instret", instret_o, exp_ret);

        // Loads from 0x8081_7F12
        load(5'd10, 3'b000, 2'd3); #2;
        chk("lb_off3", {32'd0, wb_data_o}, 64'h0000_0000_FFFF_FF80);
        tick(); exp_ret++;
        load(5'd11, 3'b100, 2'd3); #2;
        chk("lbu_off3", {32'd0, wb_data_o}, 64'h0000_0000_0000_0080);
        tick(); exp_ret++;
        load(5'd12, 3'b001, 2'd2); #2;
        chk("lh_off2", {32'd0, wb_data_o}, 64'h0000_0000_FFFF_8081);
        tick(); exp_ret++;
        load(5'd13, 3'b101, 2'd0); #2;
        chk("lhu_off0", {32'd0, wb_data_o}, 64'h0000_0000_0000_7F12);
        tick(); exp_ret++;
        idle();
        rs1_addr_i = 5'd10; rs2_addr_i = 5'd13;
        #2;
        chk("read_x10", {32'd0, rs1_data_o}, 64'h0000_0000_FFFF_FF80);
        chk("read_x13", {32'd0, rs2_data_o}, 64'h0000_0000_0000_7F12);
        chk("load_instret", instret_o, exp_ret);

        // Seed x7, both ports hitting bypass together
        alu(5'd7, 32'h7777_0007);
        rs1_addr_i = 5'd7; rs2_addr_i = 5'd7;
        #2;
        chk("dual_bypass_rs1", {32'd0, rs1_data_o}, 64'h0000_0000_7777_0007);
        chk("dual_bypass_rs2", {32'd0, rs2_data_o}, 64'h0000_0000_7777_0007);
        tick(); exp_ret++;

        // Misaligned LW off=2 to x7
        load(5'd7, 3'b010, 2'd2);
        #2;
        chk("mis_wb_en", {63'd0, wb_en_o}, 64'd0);
        chk("mis_pulse_pre", {63'd0, misalign_o}, 64'd0);
        tick(); exp_ret++;
        idle();
        #2;
        chk("mis_pulse", {63'd0, misalign_o}, 64'd1);
        chk("mis_x7_kept", {32'd0, rs1_data_o}, 64'h0000_0000_7777_0007);
        chk("mis_instret", instret_o, exp_ret);
        tick();
        chk("mis_pulse_end", {63'd0, misalign_o}, 64'd0);

        // x0 protection
        alu(5'd0, 32'h0000_1234);
        rs1_addr_i = 5'd0;
        #2;
        chk("x0_wb_en", {63'd0, wb_en_o}, 64'd0);
        chk("x0_same", {32'd0, rs1_data_o}, 64'd0);
        tick(); exp_ret++;
        idle();
        #2;
        chk("x0_later", {32'd0, rs1_data_o}, 64'd0);
        tick();
        chk("x0_later2", {32'd0, rs1_data_o}, 64'd0);

        // Invalid instruction writing x3
        alu(5'd3, 32'h3333_3333);
        invalid_in = 1'b1;
        rs1_addr_i = 5'd3;
        #2;
        chk("inv_wb_en", {63'd0, wb_en_o}, 64'd0);
        tick(); exp_inv++;
        idle();
        #2;
        chk("inv_cnt", invalid_cnt_o, exp_inv);
        chk("inv_instret", instret_o, exp_ret);
        chk("inv_x3", {32'd0, rs1_data_o}, 64'd0);

        // Three bubbles with regwrite asserted
        regwrite_in = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("bub_instret", instret_o, exp_ret);
        chk("bub_invalid", invalid_cnt_o, exp_inv);

        // Async reset between edges during a write to x9
        alu(5'd9, 32'h9999_9999);
        rs1_addr_i = 5'd9; rs2_addr_i = 5'd5;
        #2;
        reset = 1'b1;
        #1;
        chk("ar_instret", instret_o, 64'd0);
        chk("ar_invalid", invalid_cnt_o, 64'd0);
        chk("ar_misalign", {63'd0, misalign_o}, 64'd0);
        chk("ar_x5", {32'd0, rs2_data_o}, 64'd0);
        tick();
        idle();
        #2;
        reset = 1'b0;
        tick();
        chk("ar_x9", {32'd0, rs1_data_o}, 64'd0);
        chk("ar_instret_post", instret_o, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
